// File: rtl/score_uart_tx.sv
// score_uart_tx: serialises {score_p1, score_p2, game_over} as a 5-byte ASCII
// packet "S<hex p1><hex p2><status>\n" on a UART line whenever the inputs
// change. One status packet is sent after every reset release.
// Optional feature: define SCORE_UART_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (11-bit frame instead of 10-bit).
// Handshake: none. Inputs are level signals sampled every clock; busy is a
// pure status output (high from LOAD to the end of the last stop bit).
// CLK_FREQ/BAUD must be at least 2; the stop bit ends in the NEXT cycle.
module score_uart_tx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] score_p1,
   input  logic [3:0] score_p2,
   input  logic       game_over,
   output logic       uart_tx,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   // The stop bit's last cycle is spent in NEXT, so SEND leaves one early.
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
`ifdef SCORE_UART_PARITY_EN
   localparam logic [3:0] STOP_BIT = 4'd10;
`else
   localparam logic [3:0] STOP_BIT = 4'd9;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      NEXT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       snap_q, snap_d;
   logic [4:0][7:0]  pkt_q, pkt_d;
   logic             pending_q, pending_d;
   logic             rst_req_q, rst_req_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic             tx_q, tx_d;

   logic [8:0]       in_w;
   logic             diff_w;
   logic [7:0]       cur_byte;

   function automatic logic [7:0] hex_char(input logic [3:0] v);
      if (v < 4'd10) hex_char = 8'h30 + {4'h0, v};
      else           hex_char = 8'h37 + {4'h0, v};
   endfunction

   // Line level for frame position idx: start, 8 data bits LSB first,
   // optional even parity, then stop.
   function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
      frame_bit = 1'b1;
      if (idx == 4'd0)       frame_bit = 1'b0;
      else if (idx <= 4'd8)  frame_bit = data[3'(idx - 4'd1)];
`ifdef SCORE_UART_PARITY_EN
      else if (idx == 4'd9)  frame_bit = ^data;
`endif
   endfunction

   assign in_w    = {score_p1, score_p2, game_over};
   assign diff_w  = (in_w != snap_q);
   assign uart_tx = tx_q;
   assign busy    = (state_q != IDLE);

   // Select the byte currently being shifted out.
   always_comb begin
      cur_byte = 8'h0A;
      case (idx_q)
         3'd0:    cur_byte = pkt_q[0];
         3'd1:    cur_byte = pkt_q[1];
         3'd2:    cur_byte = pkt_q[2];
         3'd3:    cur_byte = pkt_q[3];
         default: cur_byte = pkt_q[4];
      endcase
   end

   // Packet FSM, bit engine and pending tracking: next-state logic.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      pkt_d     = pkt_q;
      rst_req_d = rst_req_q;
      idx_d     = idx_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      // Pending follows the live comparison, so a change that reverts before
      // LOAD leaves nothing to send; the post-reset request is held apart.
      pending_d = diff_w | rst_req_q;

      case (state_q)
         IDLE: begin
            if (pending_q) state_d = LOAD;
         end
         LOAD: begin
            if (diff_w || rst_req_q) begin
               snap_d    = in_w;
               pkt_d[0]  = 8'h53;
               pkt_d[1]  = hex_char(score_p1);
               pkt_d[2]  = hex_char(score_p2);
               pkt_d[3]  = game_over ? 8'h47 : 8'h2D;
               pkt_d[4]  = 8'h0A;
               rst_req_d = 1'b0;
               pending_d = 1'b0;
               idx_d     = 3'd0;
               baud_d    = '0;
               bit_d     = 4'd0;
               tx_d      = 1'b0;
               state_d   = SEND;
            end else begin
               // Inputs returned to the snapshot: the request is stale.
               state_d = IDLE;
            end
         end
         SEND: begin
            if (bit_q == STOP_BIT) begin
               if (baud_q == STOP_LAST) begin
                  baud_d  = '0;
                  state_d = NEXT;
               end else begin
                  baud_d = baud_q + CNT_W'(1);
               end
            end else if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               bit_d  = bit_q + 4'd1;
               tx_d   = frame_bit(bit_q + 4'd1, cur_byte);
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         NEXT: begin
            baud_d = '0;
            bit_d  = 4'd0;
            if (idx_q == 3'd4) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               tx_d    = 1'b0;
               state_d = SEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset forces the line high and requests a status packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         pkt_q     <= '0;
         pending_q <= 1'b1;
         rst_req_q <= 1'b1;
         idx_q     <= '0;
         baud_q    <= '0;
         bit_q     <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         pkt_q     <= pkt_d;
         pending_q <= pending_d;
         rst_req_q <= rst_req_d;
         idx_q     <= idx_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: doc/score_uart_tx.md
SCORE_UART_TX -- requirements
Module: score_uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 115200, meaning serial bit rate; bit period CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
REQ-003 Port clk  input  1  50 MHz system clock; the module's single clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port score_p1  input  4  player 1 score, synchronous to clk.
REQ-006 Port score_p2  input  4  player 2 score, synchronous to clk.
REQ-007 Port game_over  input  1  game-over flag, synchronous to clk.
REQ-008 Port uart_tx  output  1  serial line, idle high, LSB first.
REQ-009 Port busy  output  1  high while a packet is being transmitted.

Function
REQ-010 Each packet SHALL be exactly 5 bytes in this order: 'S' (0x53), hex(score_p1), hex(score_p2), status, LF (0x0A).
REQ-011 Hex encoding SHALL map 0-9 to 0x30-0x39 and 10-15 to 0x41-0x46 (uppercase).
REQ-012 The status byte SHALL be 'G' (0x47) when game_over=1 and '-' (0x2D) when game_over=0.
REQ-013 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, optional parity (REQ-027), and 1 stop bit (1); each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-014 Bytes within a packet SHALL be sent back to back, with no idle gap between a stop bit and the next start bit.
REQ-015 The module SHALL hold a snapshot register of {score_p1, score_p2, game_over}; a pending flag SHALL be set in any cycle where the inputs differ from the snapshot.
REQ-016 Packet-level FSM states SHALL be IDLE, LOAD, SEND, NEXT.
- IDLE -> LOAD when pending=1.
- LOAD: the inputs are copied into the snapshot and into the packet buffer, pending is cleared, byte index is set to 0; -> SEND on the next cycle.
- SEND: the bit engine transmits buffer[index]; at the end of the stop bit -> NEXT.
- NEXT: if index=4 -> IDLE, otherwise index increments -> SEND.
REQ-017 Packet contents SHALL be frozen at LOAD; input changes during SEND/NEXT SHALL only set pending.
REQ-018 Multiple input changes during one packet SHALL produce exactly one follow-up packet, carrying the values sampled at its own LOAD.
REQ-019 If the inputs change and then return to the snapshot values before LOAD, no follow-up packet SHALL be sent.
REQ-020 The first start-bit edge on uart_tx SHALL occur 2 cycles after pending is set in IDLE (1 cycle IDLE->LOAD, 1 cycle LOAD->SEND).
REQ-021 busy SHALL be 1 from LOAD through the end of the last stop bit, and 0 in IDLE.
REQ-022 The baud counter SHALL count 0 to CLKS_PER_BIT-1 and then wrap; the bit counter SHALL wrap per byte.
REQ-023 No counter SHALL overflow for any CLK_FREQ/BAUD ratio up to 4095; the counter width is sized from the parameter.
REQ-024 uart_tx SHALL be driven directly from a register so it is glitch-free.

Reset
REQ-025 While rst=1: uart_tx=1, busy=0, FSM in IDLE, counters at 0, snapshot = {0,0,0}.
REQ-026 pending SHALL reset to 1, so one status packet ("S00-\n") is sent after reset release.
- Assertion mid-packet SHALL abort the packet immediately, with the line forced high; no partial-byte recovery.

Configuration
REQ-027 With macro SCORE_UART_PARITY_EN defined, an even-parity bit SHALL be inserted between data bit 7 and the stop bit (11-bit frame).
- Without the macro, the frame SHALL be 10 bits and no parity logic SHALL be present.

Verification
REQ-028 Reset release, no input change -> "S00-\n" (0x53,0x30,0x30,0x2D,0x0A) on uart_tx; start edge 2 cycles after release; busy high for 21700 cycles (5 x 10 x 434).
REQ-029 Idle, score_p1 set to 0xA -> packet 0x53,0x41,0x30,0x2D,0x0A; each bit measured at 434 cycles.
REQ-030 During byte 2 of a packet, score_p2 stepped 3->4->5 -> current packet unchanged; exactly one follow-up packet carrying '5' (0x35); then IDLE.
REQ-031 Idle, game_over pulses 1 then 0 within 1 cycle -> at most one packet is sent; if sent, its status byte is 0x47.
REQ-032 rst asserted 1000 cycles into a packet -> uart_tx=1 and busy=0 asynchronously; after release, a fresh "S00-\n" packet is sent.
REQ-033 With SCORE_UART_PARITY_EN defined, the 'S' byte (0x53, four 1s) -> parity bit 0; a frame is 4774 cycles; the full packet is 23870 cycles.
